// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: two read ports, one write port and the
// issue/scoreboard signals. The datapath drives through master; the register file is the slave.
interface regfile_sb_if #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
);
  logic [REGBITS-1:0]      ra1;
  logic [REGBITS-1:0]      ra2;
  logic                    use1;
  logic                    use2;
  logic [WIDTH-1:0]        rd1;
  logic [WIDTH-1:0]        rd2;
  logic                    busy1;
  logic                    busy2;
  logic                    stall;
  logic                    regwrite;
  logic [REGBITS-1:0]      wa;
  logic [WIDTH-1:0]        wd;
  logic                    issue;
  logic [REGBITS-1:0]      issue_wa;
  logic [(1<<REGBITS)-1:0] pending;
  logic                    err;

  modport master (
    output ra1, ra2, use1, use2, regwrite, wa, wd, issue, issue_wa,
    input  rd1, rd2, busy1, busy2, stall, pending, err
  );

  modport slave (
    input  ra1, ra2, use1, use2, regwrite, wa, wd, issue, issue_wa,
    output rd1, rd2, busy1, busy2, stall, pending, err
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with a per-register pending-write scoreboard and stall request.
// Optional write-first forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_sb_if.slave  bus
);
  localparam int NREG = 1 << REGBITS;

  // Register 0 has no storage; it is synthesised as a constant zero on reads.
  logic [WIDTH-1:0]   r_regs [1:NREG-1];
  logic [NREG-1:1]    r_busy;
  logic               r_err;

  logic               w_wr_en;
  logic               w_iss_en;
  logic               w_viol;
  logic [REGBITS-1:0] w_ra   [2];
  logic [WIDTH-1:0]   w_rd   [2];
  logic               w_busy [2];
  logic               w_use  [2];

  assign w_ra[0]  = bus.ra1;
  assign w_ra[1]  = bus.ra2;
  assign w_use[0] = bus.use1;
  assign w_use[1] = bus.use2;

  // Qualified write/issue strobes and the double-issue violation detect.
  always_comb begin
    w_wr_en  = bus.regwrite && (bus.wa != {REGBITS{1'b0}});
    w_iss_en = bus.issue && (bus.issue_wa != {REGBITS{1'b0}});
    w_viol   = 1'b0;
    if (w_iss_en) begin
      w_viol = r_busy[bus.issue_wa] && !(w_wr_en && (bus.wa == bus.issue_wa));
    end else begin
      w_viol = 1'b0;
    end
  end

  // Register storage, busy bits and sticky error; issue wins over retire on the same register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NREG; i++) begin
        r_regs[i] <= {WIDTH{1'b0}};
      end
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_wr_en && (bus.wa == REGBITS'(i))) begin
          r_regs[i] <= bus.wd;
        end
        if (w_iss_en && (bus.issue_wa == REGBITS'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (w_wr_en && (bus.wa == REGBITS'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
      if (w_viol) begin
        r_err <= 1'b1;
      end
    end
  end

  // Combinational read ports with optional write-first forwarding.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd[p]   = {WIDTH{1'b0}};
      w_busy[p] = 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (w_wr_en && (bus.wa == w_ra[p])) begin
        w_rd[p]   = bus.wd;
        w_busy[p] = 1'b0;
      end else if (w_ra[p] != {REGBITS{1'b0}}) begin
        w_rd[p]   = r_regs[w_ra[p]];
        w_busy[p] = r_busy[w_ra[p]];
      end else begin
        w_rd[p]   = {WIDTH{1'b0}};
        w_busy[p] = 1'b0;
      end
`else
      if (w_ra[p] != {REGBITS{1'b0}}) begin
        w_rd[p]   = r_regs[w_ra[p]];
        w_busy[p] = r_busy[w_ra[p]];
      end else begin
        w_rd[p]   = {WIDTH{1'b0}};
        w_busy[p] = 1'b0;
      end
`endif
    end
  end

  assign bus.rd1     = w_rd[0];
  assign bus.rd2     = w_rd[1];
  assign bus.busy1   = w_busy[0];
  assign bus.busy2   = w_busy[1];
  assign bus.stall   = (w_use[0] && w_busy[0]) || (w_use[1] && w_busy[1]);
  assign bus.pending = {r_busy, 1'b0};
  assign bus.err     = r_err;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  regfile_sb_if #(.WIDTH(8), .REGBITS(3)) bus ();

  regfile_sb #(.WIDTH(8), .REGBITS(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.regwrite = 1'b0;
    bus.issue    = 1'b0;
  endtask

  initial begin
    bus.ra1 = 3'd0; bus.ra2 = 3'd0; bus.use1 = 1'b0; bus.use2 = 1'b0;
    bus.regwrite = 1'b0; bus.wa = 3'd0; bus.wd = 8'h00;
    bus.issue = 1'b0; bus.issue_wa = 3'd0;
    #12 reset_n = 1'b1;
    tick();

    // Build some state, then reset in the middle of a cycle.
    bus.regwrite = 1'b1; bus.wa = 3'd3; bus.wd = 8'h77;
    bus.issue = 1'b1; bus.issue_wa = 3'd6;
    tick();
    idle();
    bus.ra1 = 3'd3; bus.ra2 = 3'd6; bus.use1 = 1'b1; bus.use2 = 1'b1;
    #1;
    chk("pre_rst_rd1", 32'(bus.rd1), 32'h77);
    chk("pre_rst_stall", 32'(bus.stall), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_rd1", 32'(bus.rd1), 32'h0);
    chk("rst_rd2", 32'(bus.rd2), 32'h0);
    chk("rst_busy2", 32'(bus.busy2), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_pending", 32'(bus.pending), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    #1 reset_n = 1'b1;
    bus.use1 = 1'b0; bus.use2 = 1'b0;

    // First edge after reset is a normal write.
    bus.regwrite = 1'b1; bus.wa = 3'd3; bus.wd = 8'h5A; bus.ra1 = 3'd3;
    tick();
    idle();
    #1;
    chk("wr_r3", 32'(bus.rd1), 32'h5A);
    bus.regwrite = 1'b1; bus.wa = 3'd0; bus.wd = 8'hFF; bus.ra1 = 3'd0;
    tick();
    idle();
    #1;
    chk("r0_zero", 32'(bus.rd1), 32'h0);
    chk("r0_pending", 32'(bus.pending), 32'h0);

    // Stall and retire on r5.
    bus.issue = 1'b1; bus.issue_wa = 3'd5; bus.ra1 = 3'd5; bus.use1 = 1'b1;
    #1;
    chk("issue_no_same_stall", 32'(bus.stall), 32'h0);
    tick();
    idle();
    #1;
    chk("stall_r5", 32'(bus.stall), 32'h1);
    chk("busy1_r5", 32'(bus.busy1), 32'h1);
    chk("pending_r5", 32'(bus.pending), 32'h20);
    bus.regwrite = 1'b1; bus.wa = 3'd5; bus.wd = 8'h33;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("retire_stall_same", 32'(bus.stall), 32'h0);
    chk("retire_rd1_same", 32'(bus.rd1), 32'h33);
`else
    chk("retire_stall_same", 32'(bus.stall), 32'h1);
    chk("retire_rd1_same", 32'(bus.rd1), 32'h0);
`endif
    tick();
    idle();
    #1;
    chk("retire_stall_next", 32'(bus.stall), 32'h0);
    chk("retire_rd1_next", 32'(bus.rd1), 32'h33);
    chk("retire_pending", 32'(bus.pending), 32'h0);
    bus.use1 = 1'b0;

    // Same-cycle issue and write to r2.
    bus.issue = 1'b1; bus.issue_wa = 3'd2;
    bus.regwrite = 1'b1; bus.wa = 3'd2; bus.wd = 8'h11; bus.ra2 = 3'd2;
    #1;
    chk("same_busy2_now", 32'(bus.busy2), 32'h0);
`ifdef REGFILE_BYPASS_EN
    chk("same_rd2_now", 32'(bus.rd2), 32'h11);
`else
    chk("same_rd2_now", 32'(bus.rd2), 32'h0);
`endif
    tick();
    idle();
    #1;
    chk("same_rd2", 32'(bus.rd2), 32'h11);
    chk("same_busy2", 32'(bus.busy2), 32'h1);
    chk("same_pending", 32'(bus.pending), 32'h04);
    chk("same_err", 32'(bus.err), 32'h0);
    bus.regwrite = 1'b1; bus.wa = 3'd2; bus.wd = 8'h22;
    tick();
    idle();
    #1;
    chk("r2_retired", 32'(bus.pending), 32'h0);

    // Double issue to r4 sets sticky err.
    bus.issue = 1'b1; bus.issue_wa = 3'd4;
    tick();
    #1;
    chk("dbl_err_first", 32'(bus.err), 32'h0);
    tick();
    idle();
    #1;
    chk("dbl_err_set", 32'(bus.err), 32'h1);
    chk("dbl_pending", 32'(bus.pending), 32'h10);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("err_sticky", 32'(bus.err), 32'h1);
    end

    // Mid-operation reset with r1, r6 busy and r7 written.
    bus.issue = 1'b1; bus.issue_wa = 3'd1;
    tick();
    bus.issue_wa = 3'd6;
    tick();
    bus.issue = 1'b0;
    bus.regwrite = 1'b1; bus.wa = 3'd7; bus.wd = 8'hAA;
    tick();
    idle();
    bus.ra1 = 3'd7; bus.ra2 = 3'd1; bus.use1 = 1'b1; bus.use2 = 1'b1;
    #1;
    chk("mid_pre_rd1", 32'(bus.rd1), 32'hAA);
    chk("mid_pre_stall", 32'(bus.stall), 32'h1);
    chk("mid_pre_pending", 32'(bus.pending), 32'h52);
    reset_n = 1'b0;
    #1;
    chk("mid_pending", 32'(bus.pending), 32'h0);
    chk("mid_rd1", 32'(bus.rd1), 32'h0);
    chk("mid_stall", 32'(bus.stall), 32'h0);
    chk("mid_err", 32'(bus.err), 32'h0);
    #1 reset_n = 1'b1;
    bus.regwrite = 1'b1; bus.wa = 3'd1; bus.wd = 8'h01; bus.ra1 = 3'd1;
    tick();
    idle();
    #1;
    chk("post_rst_wr", 32'(bus.rd1), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a per-register pending-write scoreboard, the next-generation register file for the TinyMIPS datapath. It provides two combinational read ports and one clocked write port. Register 0 is hardwired to zero. A busy bit per register tracks results still in flight, such as loads or multi-cycle ops. From these bits the block raises a stall request to the control unit, so the datapath no longer needs an external hazard counter.

## Interface
- WIDTH, 8: data width of each register.
- REGBITS, 3: address width; the file holds 2^REGBITS registers.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- ra1, ra2  in  REGBITS  read addresses (RS, RT).
- use1, use2  in  1  the current instruction actually consumes ra1 / ra2.
- rd1, rd2  out  WIDTH  read data.
- busy1, busy2  out  1  the addressed source register has a pending write.
- stall  out  1  hazard request to control.
- regwrite  in  1  write enable; the write also retires the pending state of wa.
- wa  in  REGBITS  write address (RD).
- wd  in  WIDTH  write data.
- issue  in  1  mark a destination as pending.
- issue_wa  in  REGBITS  destination being marked.
- pending  out  2^REGBITS  busy bit vector; bit i is register i, and bit 0 is always 0.
- err  out  1  sticky scoreboard violation flag.

## Operation
- Storage:
  - REGS[1..2^REGBITS-1], each WIDTH bits.
  - busy[1..2^REGBITS-1], 1 bit each.
  - err, 1 bit.
  - There is no storage for register 0.
- Reset (reset_n=0): all REGS are 0, all busy bits are 0, err is 0. Outputs while in reset:
  - rd1, rd2 = 0.
  - busy1, busy2, stall, pending, err = 0.
- Write: at posedge clk, if regwrite=1 and wa≠0:
  - REGS[wa] ← wd.
  - busy[wa] ← 0, unless an issue to the same register occurs in the same cycle (see below).
  - A write with wa=0 is discarded.
- Issue: at posedge clk, if issue=1 and issue_wa≠0, busy[issue_wa] ← 1.
  - An issue with issue_wa=0 is ignored.
- Same register, same cycle (issue and write): the data is stored and busy ends at 1. The new producer owns the register.
- Violation: issue to a register whose busy bit is already 1, with no retiring write to that register in the same cycle:
  - err ← 1 and stays 1 until reset.
  - busy stays 1.
- Write to a non-busy register: legal, and clears nothing extra.
- Read: rdN = 0 if raN=0, otherwise REGS[raN]. Bypassing is covered under Configuration.
- busyN = (raN≠0) & busy[raN], masked as described under Configuration.
- stall = (use1 & busy1) | (use2 & busy2).
- Arithmetic: none. No data width conversion takes place; wd is stored as given.

## Timing
- Read ports are purely combinational: zero latency from raN to rdN, busyN and stall.
- Write becomes visible on rdN:
  - without bypass, in the cycle after the write edge;
  - with bypass, in the same cycle.
- Issue sets busy visibly in the cycle after the issue edge. Issuing does not create a same-cycle stall.
- err asserts in the cycle after the violating edge.
- reset_n assertion takes effect immediately, even in the middle of an operation: state clears without waiting for clk.
- The first edge after reset_n deasserts is a normal operating edge.

## Configuration
- REGFILE_BYPASS_EN defined: write-first forwarding is enabled.
  - If regwrite=1, wa≠0 and wa=raN, then rdN = wd and busyN = 0 in that same cycle.
  - The one exception is an issue to that register in the same cycle: busyN is still 0 this cycle and is 1 from the next.
- REGFILE_BYPASS_EN undefined: no forwarding.
  - rdN shows the old REGS value and busyN reflects the current busy bit.
  - A consumer stalls one extra cycle after writeback.

## Test plan
- Reset, then write: assert reset_n=0 with an arbitrary state present, release, write r3=0x5A. Required: all outputs are 0 during reset; ra1=3 reads 0x5A on the next cycle. Then write r0=0xFF: ra1=0 still reads 0.
- Stall and retire: issue r5, then hold use1=1, ra1=5. Required: stall=1 from the next cycle, pending=8'b0010_0000. Then write r5=0x33. Required:
  - with bypass, stall=0 and rd1=0x33 in the write cycle;
  - without bypass, both are seen one cycle later.
- Same-cycle issue and write to r2 with wd=0x11. Required: REGS[2]=0x11, busy[2]=1 afterwards, err=0.
- Double issue: issue r4 twice on consecutive cycles with no write. Required: err=1 from the following cycle and it stays 1 through 10 idle cycles; it clears only on reset_n=0.
- Mid-operation reset: set busy on r1 and r6 and write r7=0xAA, then pulse reset_n low between clock edges. Required: pending=0, rd(7)=0 and stall=0 immediately, before the next clk edge.
